// File: rtl/adjust_mode_controller.sv
// Time-adjust sequencing FSM: synchronises the next/increment pins, steps focus
// hours->minutes->seconds and strobes the adjust/timer load lines. Optional ADJUST_TIMEOUT_EN.
module adjust_mode_controller #(
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adjustment_next,
  input  logic       adjustment_increment,
  input  logic       tick_1hz,
  output logic [2:0] adjust_mode,
  output logic       select_adjust,
  output logic       adjust_load,
  output logic       timer_load
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADJ_H  = 3'd1,
    ADJ_M  = 3'd2,
    ADJ_S  = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam int unsigned LAST = SYNC_STAGES - 1;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] next_sync, inc_sync;
  logic                   next_dly, inc_dly;
  logic                   next_edge, inc_edge, inc_level, activity;
  logic                   in_adj, timeout;

  logic [2:0] adjust_mode_d;
  logic       select_adjust_d, adjust_load_d, timer_load_d;

  // Input synchronisers plus one delayed copy of the last stage for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_sync <= '0;
      inc_sync  <= '0;
      next_dly  <= 1'b0;
      inc_dly   <= 1'b0;
    end else begin
      next_sync <= {next_sync[SYNC_STAGES-2:0], adjustment_next};
      inc_sync  <= {inc_sync[SYNC_STAGES-2:0], adjustment_increment};
      next_dly  <= next_sync[LAST];
      inc_dly   <= inc_sync[LAST];
    end
  end

  assign next_edge = next_sync[LAST] & ~next_dly;
  assign inc_level = inc_sync[LAST];
  assign inc_edge  = inc_sync[LAST] & ~inc_dly;
  assign activity  = next_edge | inc_edge | inc_level;
  assign in_adj    = (state_q == ADJ_H) || (state_q == ADJ_M) || (state_q == ADJ_S);

`ifdef ADJUST_TIMEOUT_EN
  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_TICKS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adj_next;

  assign timeout  = in_adj && (cnt_q == CNT_MAX) && !activity;
  assign adj_next = (state_d == ADJ_H) || (state_d == ADJ_M) || (state_d == ADJ_S);

  // Inactivity counter: restarts on ADJ_H entry or activity, saturates at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (!adj_next || (state_q == IDLE) || activity) begin
      cnt_d = '0;
    end else if (tick_1hz && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign unused_cfg = tick_1hz ^ (^TIMEOUT_TICKS);
`endif

  // Next state and next registered output values
  always_comb begin
    state_d       = state_q;
    adjust_load_d = 1'b0;
    timer_load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (next_edge) begin
          state_d       = ADJ_H;
          adjust_load_d = 1'b1;
        end
      end
      ADJ_H: begin
        if (next_edge)    state_d = ADJ_M;
        else if (timeout) state_d = IDLE;
      end
      ADJ_M: begin
        if (next_edge)    state_d = ADJ_S;
        else if (timeout) state_d = IDLE;
      end
      ADJ_S: begin
        if (next_edge) begin
          state_d      = COMMIT;
          timer_load_d = 1'b1;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    adjust_mode_d = 3'b000;
    case (state_d)
      ADJ_H:   adjust_mode_d = 3'b100;
      ADJ_M:   adjust_mode_d = 3'b010;
      ADJ_S:   adjust_mode_d = 3'b001;
      default: adjust_mode_d = 3'b000;
    endcase
    // COMMIT keeps the adjust register on the display for its single cycle
    select_adjust_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      adjust_mode   <= 3'b000;
      select_adjust <= 1'b0;
      adjust_load   <= 1'b0;
      timer_load    <= 1'b0;
    end else begin
      state_q       <= state_d;
      adjust_mode   <= adjust_mode_d;
      select_adjust <= select_adjust_d;
      adjust_load   <= adjust_load_d;
      timer_load    <= timer_load_d;
    end
  end

endmodule

// File: tb/tb_adjust_mode_controller.sv
// Bench for adjust_mode_controller: directed scenarios plus random pins, compared
// every cycle against a focus-index/idle-tick reference model.
module tb_adjust_mode_controller;

  localparam int unsigned TICKS = 10;
  localparam int unsigned SYNC  = 2;
`ifdef ADJUST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       adjustment_next = 1'b0;
  logic       adjustment_increment = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [2:0] adjust_mode;
  logic       select_adjust, adjust_load, timer_load;

  int errors = 0;
  int checks = 0;
  int n_al = 0;
  int n_tl = 0;

  adjust_mode_controller #(.TIMEOUT_TICKS(TICKS), .SYNC_STAGES(SYNC)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .adjustment_next     (adjustment_next),
    .adjustment_increment(adjustment_increment),
    .tick_1hz            (tick_1hz),
    .adjust_mode         (adjust_mode),
    .select_adjust       (select_adjust),
    .adjust_load         (adjust_load),
    .timer_load          (timer_load)
  );

  always #5 clk = ~clk;

  // Reference model: focus 0=idle 1=hours 2=minutes 3=seconds 4=commit
  int   m_focus, m_old, m_cnt;
  bit   hist_n[$], hist_i[$];
  bit   m_ne, m_il, m_act, m_to;
  logic [2:0] exp_mode;
  logic exp_sel, exp_al, exp_tl;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_focus = 0;
      m_cnt   = 0;
      hist_n.delete();
      hist_i.delete();
      for (int k = 0; k < SYNC + 2; k++) begin
        hist_n.push_back(1'b0);
        hist_i.push_back(1'b0);
      end
      exp_mode = 3'b000;
      exp_sel  = 1'b0;
      exp_al   = 1'b0;
      exp_tl   = 1'b0;
    end else begin
      hist_n.push_back(adjustment_next);
      void'(hist_n.pop_front());
      hist_i.push_back(adjustment_increment);
      void'(hist_i.pop_front());
      m_ne  = hist_n[hist_n.size() - 1 - SYNC] && !hist_n[hist_n.size() - 2 - SYNC];
      m_il  = hist_i[hist_i.size() - 1 - SYNC];
      m_act = m_ne || m_il;
      m_to  = TO_EN && (m_focus >= 1) && (m_focus <= 3) && (m_cnt == TICKS) && !m_act;
      m_old = m_focus;
      if (m_old == 0)      m_focus = m_ne ? 1 : 0;
      else if (m_old == 4) m_focus = 0;
      else if (m_ne)       m_focus = m_old + 1;
      else if (m_to)       m_focus = 0;
      if (m_focus < 1 || m_focus > 3 || m_old == 0 || m_act) m_cnt = 0;
      else if (tick_1hz && m_cnt < TICKS) m_cnt = m_cnt + 1;
      exp_mode = (m_focus == 1) ? 3'b100 : (m_focus == 2) ? 3'b010 :
                 (m_focus == 3) ? 3'b001 : 3'b000;
      exp_sel  = (m_focus != 0);
      exp_al   = (m_old == 0) && (m_focus == 1);
      exp_tl   = (m_focus == 4);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and compare all outputs on the falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check("mode", 32'(adjust_mode), 32'(exp_mode));
    check("select_adjust", 32'(select_adjust), 32'(exp_sel));
    check("adjust_load", 32'(adjust_load), 32'(exp_al));
    check("timer_load", 32'(timer_load), 32'(exp_tl));
    if (adjust_load) n_al++;
    if (timer_load) n_tl++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    adjustment_next = 1'b0;
    adjustment_increment = 1'b0;
    tick_1hz = 1'b0;
    steps(2);
    reset_n = 1'b1;
    step();
  endtask

  task automatic next_pulse(input int hold);
    adjustment_next = 1'b1;
    steps(hold);
    adjustment_next = 1'b0;
    steps(4);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      steps(3);
    end
  endtask

  initial begin
    #1 reset_n = 1'b0;
    steps(3);
    reset_n = 1'b1;
    step();
    check("reset_mode", 32'(adjust_mode), 32'd0);
    check("reset_sel", 32'(select_adjust), 32'd0);

    // Idle with ticks: nothing happens
    n_al = 0; n_tl = 0;
    ticks(20);
    check("idle_mode", 32'(adjust_mode), 32'd0);
    check("idle_loads", 32'(n_al + n_tl), 32'd0);

    // Full cycle through the four focus positions
    n_al = 0; n_tl = 0;
    next_pulse(4);
    check("t2_hours", 32'(adjust_mode), 32'd4);
    next_pulse(10);
    check("t2_minutes", 32'(adjust_mode), 32'd2);
    next_pulse(2);
    check("t2_seconds", 32'(adjust_mode), 32'd1);
    next_pulse(3);
    check("t2_done", 32'(adjust_mode), 32'd0);
    check("t2_sel", 32'(select_adjust), 32'd0);
    check("t2_adjust_load_cnt", 32'(n_al), 32'd1);
    check("t2_timer_load_cnt", 32'(n_tl), 32'd1);

    // Timeout after ten idle ticks, nothing committed
    do_reset();
    n_tl = 0;
    next_pulse(3);
    ticks(10);
    steps(2);
    check("t3_timeout", 32'(adjust_mode), TO_EN ? 32'd0 : 32'd4);
    check("t3_no_commit", 32'(n_tl), 32'd0);

    // Increment at tick 9 restarts the inactivity count
    do_reset();
    next_pulse(3);
    ticks(9);
    adjustment_increment = 1'b1;
    step();
    adjustment_increment = 1'b0;
    steps(3);
    ticks(1);
    check("t3_still_hours", 32'(adjust_mode), 32'd4);
    ticks(9);
    steps(2);
    check("t3_late_timeout", 32'(adjust_mode), TO_EN ? 32'd0 : 32'd4);

    // Held increment keeps minutes focus alive
    do_reset();
    next_pulse(3);
    next_pulse(3);
    adjustment_increment = 1'b1;
    ticks(30);
    check("t4_held", 32'(adjust_mode), 32'd2);
    adjustment_increment = 1'b0;
    steps(3);
    ticks(10);
    steps(2);
    check("t4_release", 32'(adjust_mode), TO_EN ? 32'd0 : 32'd2);

    // Reset in seconds focus clears outputs immediately, no commit afterwards
    do_reset();
    n_tl = 0;
    next_pulse(3);
    next_pulse(3);
    next_pulse(3);
    check("t5_seconds", 32'(adjust_mode), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_async_mode", 32'(adjust_mode), 32'd0);
    check("t5_async_sel", 32'(select_adjust), 32'd0);
    steps(3);
    reset_n = 1'b1;
    steps(8);
    check("t5_no_commit", 32'(n_tl), 32'd0);
    check("t5_idle", 32'(adjust_mode), 32'd0);

    // Next edge lands on the same edge as the terminal tick in minutes
    do_reset();
    next_pulse(3);
    next_pulse(3);
    ticks(9);
    adjustment_next = 1'b1;
    steps(SYNC);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    steps(3);
    adjustment_next = 1'b0;
    steps(3);
    ticks(5);
    check("t6_seconds", 32'(adjust_mode), 32'd1);

    // Random pins checked against the model every cycle
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) adjustment_next = ~adjustment_next;
      if ($urandom_range(0, 19) == 0) adjustment_increment = ~adjustment_increment;
      tick_1hz = !tick_1hz && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 799) == 0) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
